// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES byte tables, FSM state type and inverse-cipher helper functions
package aes_pkg;

  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, DONE} state_e;
  typedef logic [0:127] block_t;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
    return o;
  endfunction

  // Byte 4*c+r holds row r of column c; row r rotates right by r columns.
  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
    return o;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t o;
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        a      = s[8*(4*c+i) +: 8];
        x2     = xtime(a);
        x4     = xtime(x2);
        x8     = xtime(x4);
        m9[i]  = x8 ^ a;
        m11[i] = x8 ^ x2 ^ a;
        m13[i] = x8 ^ x4 ^ a;
        m14[i] = x8 ^ x4 ^ x2;
      end
      o[8*(4*c+0) +: 8] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
      o[8*(4*c+1) +: 8] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
      o[8*(4*c+2) +: 8] = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
      o[8*(4*c+3) +: 8] = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [0:127] state_i,
  input  logic [0:127] rkey_i,
  input  logic         last_i,
  output logic [0:127] state_o
);

  block_t shifted, subbed, keyed;

  assign shifted = inv_shift_rows(state_i);
  assign subbed  = inv_sub_bytes(shifted);
  assign keyed   = subbed ^ rkey_i;
  // The final round (key 0) has no InvMixColumns.
  assign state_o = last_i ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_dec_iter.sv
// rtl/aes_dec_iter.sv - iterative AES decryptor, one round per cycle; AES_DEC_KEY_CACHE_EN enables key-schedule reuse
module aes_dec_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:127]        in_data,
  input  logic [0:KEY_BITS-1] in_key,
  input  logic                in_key_reuse,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:127]        out_data
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int WW = $clog2(NW);
  localparam int KW = $clog2(NK);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_dec_iter: KEY_BITS must be 128, 192 or 256");
  end

  state_e         state_q, state_d;
  block_t         blk_q, blk_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [WW-1:0]  kidx_q, kidx_d;
  logic [KW-1:0]  kmod_q, kmod_d;
  logic [3:0]     rci_q, rci_d;
  logic [31:0]    sched_q [NW];
  logic [31:0]    win_q [NK];

  logic           accept, hit, kexp_last;
  logic [31:0]    prev_w, temp_w, new_word;
  logic [3:0]     rk_sel;
  logic [WW-1:0]  rk_base;
  block_t         round_key, round_out;

  assign accept    = in_valid && (state_q == IDLE);
  assign kexp_last = (state_q == KEXP) && (kidx_q == WW'(NW - 1));

`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cache_valid_q <= 1'b0;
    else if (accept && !in_key_reuse) cache_valid_q <= 1'b0;
    else if (kexp_last)               cache_valid_q <= 1'b1;
  end

  assign hit = accept && in_key_reuse && cache_valid_q;
`else
  logic unused_key_reuse;
  assign unused_key_reuse = in_key_reuse;
  assign hit = 1'b0;
`endif

  // win_q holds the last NK schedule words: [0] is w[i-NK], [NK-1] is w[i-1].
  assign prev_w = win_q[NK-1];
  always_comb begin
    if (kmod_q == '0)
      temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon(rci_q), 24'h000000};
    else if (NK > 6 && int'(kmod_q) == 4)
      temp_w = sub_word(prev_w);
    else
      temp_w = prev_w;
    new_word = win_q[0] ^ temp_w;
  end

  always_ff @(posedge clk) begin
    if (accept && !hit) begin
      for (int j = 0; j < NK; j++) begin
        win_q[j]   <= in_key[32*j +: 32];
        sched_q[j] <= in_key[32*j +: 32];
      end
    end else if (state_q == KEXP) begin
      for (int j = 0; j < NK - 1; j++) win_q[j] <= win_q[j+1];
      win_q[NK-1]     <= new_word;
      sched_q[kidx_q] <= new_word;
    end
  end

  assign rk_sel    = (state_q == INIT) ? 4'(NR) : rnd_q;
  assign rk_base   = WW'({rk_sel, 2'b00});
  assign round_key = {sched_q[rk_base], sched_q[rk_base | WW'(1)],
                      sched_q[rk_base | WW'(2)], sched_q[rk_base | WW'(3)]};

  aes_inv_round u_round (
    .state_i (blk_q),
    .rkey_i  (round_key),
    .last_i  (rnd_q == '0),
    .state_o (round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = hit ? INIT : KEXP;
      KEXP:    if (kexp_last) state_d = INIT;
      INIT:    state_d = ROUND;
      ROUND:   if (rnd_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = blk_q;
  end

  always_comb begin
    blk_d  = blk_q;
    rnd_d  = rnd_q;
    kidx_d = kidx_q;
    kmod_d = kmod_q;
    rci_d  = rci_q;
    case (state_q)
      IDLE: if (in_valid) begin
        blk_d  = in_data;
        kidx_d = WW'(NK);
        kmod_d = '0;
        rci_d  = 4'd1;
      end
      KEXP: begin
        kidx_d = kidx_q + WW'(1);
        kmod_d = (kmod_q == KW'(NK - 1)) ? '0 : kmod_q + KW'(1);
        if (kmod_q == '0) rci_d = rci_q + 4'd1;
      end
      INIT: begin
        blk_d = blk_q ^ round_key;
        rnd_d = 4'(NR - 1);
      end
      ROUND: begin
        blk_d = round_out;
        if (rnd_q != '0) rnd_d = rnd_q - 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q  <= '0;
      rnd_q  <= '0;
      kidx_q <= '0;
      kmod_q <= '0;
      rci_q  <= '0;
    end else begin
      blk_q  <= blk_d;
      rnd_q  <= rnd_d;
      kidx_q <= kidx_d;
      kmod_q <= kmod_d;
      rci_q  <= rci_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_iter.sv
// tb/tb_aes_dec_iter.sv - bench for aes_dec_iter at 128/192/256-bit keys
module tb_aes_dec_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready;
  logic [0:127] in_data;
  logic [0:255] key_v;
  logic         in_key_reuse;
  logic [0:127] out_data [3];

  int n_pass = 0;
  int n_total = 0;
  logic [0:127] exp_q [$];
  int           lat_q [$];

  localparam logic [0:127] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:255] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [0:255] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:255] K_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 51;
`endif

  always #5 clk = ~clk;

  aes_dec_iter #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data), .in_key(key_v[0:127]), .in_key_reuse(in_key_reuse),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
  );

  aes_dec_iter #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data), .in_key(key_v[0:191]), .in_key_reuse(in_key_reuse),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
  );

  aes_dec_iter #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data), .in_key(key_v), .in_key_reuse(in_key_reuse),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Offers one block, waits for the result and compares it with the queued expectation.
  task automatic run_block(input int d, input logic [0:127] ct, input logic [0:255] key,
                           input logic reuse, input logic [0:127] pt, input int lat,
                           input int hold);
    int cyc;
    int exp_lat;
    logic [0:127] exp_pt;
    logic [0:127] held;
    @(negedge clk);
    check("in_ready_idle", in_ready[d], 1);
    in_data      = ct;
    key_v        = key;
    in_key_reuse = reuse;
    in_valid[d]  = 1'b1;
    exp_q.push_back(pt);
    lat_q.push_back(lat);
    @(negedge clk);
    in_valid[d]  = 1'b0;
    in_data      = '1;
    key_v        = '1;
    in_key_reuse = 1'b0;
    cyc = 0;
    while (out_valid[d] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    exp_pt  = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    check("latency", cyc, exp_lat);
    check("plaintext", out_data[d], exp_pt);
    held = out_data[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid[d], 1);
      check("hold_data", out_data[d], held);
      check("hold_in_ready", in_ready[d], 0);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check("valid_drop", out_valid[d], 0);
    check("ready_back", in_ready[d], 1);
  endtask

  initial begin
    int seen;
    rst          = 1'b1;
    in_valid     = '0;
    out_ready    = '0;
    in_data      = '0;
    key_v        = '0;
    in_key_reuse = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready", in_ready[d], 1);
      check("rst_out_valid", out_valid[d], 0);
      check("rst_out_data", out_data[d], 0);
    end
    rst = 1'b0;

    run_block(0, CT128, K128, 1'b0, PT, 51, 0);
    run_block(0, CT_B, K_B, 1'b0, PT_B, 51, 0);
    run_block(1, CT192, K192, 1'b0, PT, 59, 20);
    run_block(2, CT256, K256, 1'b0, PT, 67, 0);

    // Abort a block mid-ROUND with reset.
    @(negedge clk);
    in_data     = CT128;
    key_v       = K128;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (45) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready[0], 1);
    check("abort_out_valid", out_valid[0], 0);
    check("abort_out_data", out_data[0], 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) seen = 1;
    end
    check("no_spurious_valid", seen, 0);
    run_block(0, CT128, K128, 1'b0, PT, 51, 0);

    run_block(0, CT128, K128, 1'b1, PT, HIT_LAT, 0);
    run_block(0, CT_B, K_B, 1'b0, PT_B, 51, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_block(0, CT128, K128, 1'b1, PT, 51, 0);
    run_block(0, CT128, K128, 1'b1, PT, HIT_LAT, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_dec_iter.md
AES_DEC_ITER -- requirements
Module: aes_dec_iter

Interface
REQ-001 Parameter KEY_BITS, default 128, cipher key length; legal values 128/192/256; any other value SHALL be an elaboration error.
REQ-002 Derived localparams SHALL be NK = KEY_BITS/32 and NR = NK+6, giving 10/12/14 rounds.
REQ-003 Port clk, input, 1, single clock; all state SHALL be on its rising edge.
REQ-004 Port rst, input, 1, reset that is asynchronous and active-high.
REQ-005 Port in_valid, input, 1, ciphertext/key offered.
REQ-006 Port in_ready, output, 1, core can accept a block.
REQ-007 Port in_data, input, [0:127], ciphertext; bit 0 is the MSB of byte 0.
REQ-008 Port in_key, input, [0:KEY_BITS-1], cipher key in big-endian order.
REQ-009 Port in_key_reuse, input, 1, reuse the cached key schedule (meaningful only with REQ-030).
REQ-010 Port out_valid, output, 1, plaintext valid.
REQ-011 Port out_ready, input, 1, consumer accepts the plaintext.
REQ-012 Port out_data, output, [0:127], plaintext.

Function
REQ-013 FSM states SHALL be IDLE, KEXP, INIT, ROUND and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; accept occurs when in_valid and in_ready are both 1; no overlap of blocks.
REQ-015 On accept: capture in_data into the state register and in_key into the Nk seed words; go to KEXP, or to INIT when a reuse hit occurs (REQ-030).
REQ-016 KEXP SHALL generate one 32-bit schedule word per cycle per FIPS-197 (RotWord/SubWord/Rcon; extra SubWord when NK=8 and i mod 8 = 4).
REQ-017 KEXP SHALL last LK = 4*(NR+1)-NK cycles (40/46/52), storing words into a 4*(NR+1)-entry array.
REQ-018 INIT SHALL take 1 cycle: state ^= roundkey[NR].
REQ-019 ROUND SHALL take NR cycles with round counter r running NR-1 down to 0, each cycle applying InvShiftRows, InvSubBytes, AddRoundKey(roundkey[r]) and then InvMixColumns; InvMixColumns SHALL be omitted when r=0.
REQ-020 DONE SHALL assert out_valid with out_data equal to the state register, holding it stable until out_ready is 1.
REQ-021 On the handshake in DONE: go to IDLE; out_valid SHALL drop on the next cycle.
REQ-022 Latency from the accept edge to out_valid high SHALL be LK+1+NR cycles (51/59/67), or 1+NR (11/13/15) on a reuse hit.
REQ-023 in_valid SHALL be ignored outside IDLE; in_data and in_key need not be held after accept.
REQ-024 out_data SHALL be don't-care while out_valid is 0, but SHALL not toggle while in DONE.

Reset
REQ-025 While rst is high: state IDLE, in_ready=1, out_valid=0, out_data=0, round counter 0, cache_valid=0.
REQ-026 Reset asserted in any state SHALL abort the block immediately; no output for the aborted block.
REQ-027 The schedule array SHALL need no reset; its contents are qualified by cache_valid.

Configuration
REQ-028 Macro AES_DEC_KEY_CACHE_EN SHALL control key-schedule reuse.
REQ-029 Macro undefined: in_key_reuse SHALL be ignored and every accept SHALL run KEXP.
REQ-030 Macro defined:
- A reuse hit is in_key_reuse=1 and cache_valid=1 at accept; a hit SHALL skip KEXP and use the stored schedule.
- cache_valid SHALL set at KEXP completion.
- cache_valid SHALL clear on reset and on any accept with in_key_reuse=0.

Structure
REQ-031 Package aes_pkg SHALL hold:
- forward S-box and inverse S-box tables;
- the Rcon table;
- the state enum typedef;
- functions xtime, InvMixColumns and InvShiftRows.
REQ-032 Sub-module aes_inv_round SHALL be purely combinational, with inputs state, round key and last flag, and output next state; it is instantiated once.

Verification
REQ-033 KEY_BITS=128, ct 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f -> out_data 00112233445566778899aabbccddeeff, out_valid 51 cycles after accept.
REQ-034 KEY_BITS=192, ct dda97ca4864cdfe06eaf70a0ec0d7191, key 000102...1617 -> 00112233445566778899aabbccddeeff, latency 59.
REQ-035 KEY_BITS=256, ct 8ea2b7ca516745bfeafc49904b496089, key 000102...1e1f -> 00112233445566778899aabbccddeeff, latency 67.
REQ-036 Hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_data constant, in_ready stays 0; release -> IDLE the next cycle.
REQ-037 Assert rst mid-ROUND, release, then send the REQ-033 vector -> no spurious out_valid; correct result returned at latency 51.
REQ-038 With AES_DEC_KEY_CACHE_EN: send the REQ-033 vector, then repeat it with in_key_reuse=1 -> same plaintext at latency 11; reuse request after reset -> full latency 51.
